// File: rtl/mem_ctrl_if.sv
// Bundle of the mem_ctrl request/response and RAM/IO bus signals.
//   slave  : the controller side (mem_ctrl)
//   master : the environment side (LSB, instruction fetch, RAM/IO)
// Signals:
//   rdy_in, clear_flag              global ready / mispredict flush
//   mem_din, mem_dout, mem_a, mem_wr RAM/IO byte bus
//   io_buffer_full                  UART buffer full, blocks IO-window writes
//   full_mem, addr, data, op        LSB request (level until mem_ready)
//   mem_ready, mem_val              LSB completion pulse and load result
//   if_req, if_addr                 fetch request (level until if_ready)
//   if_ready, if_data               fetch completion pulse and word
interface mem_ctrl_if;
  logic        rdy_in;
  logic        clear_flag;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        full_mem;
  logic [31:0] addr;
  logic [31:0] data;
  logic [3:0]  op;
  logic        mem_ready;
  logic [31:0] mem_val;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_data;

  modport slave (
    input  rdy_in, clear_flag, mem_din, io_buffer_full,
           full_mem, addr, data, op, if_req, if_addr,
    output mem_dout, mem_a, mem_wr, mem_ready, mem_val, if_ready, if_data
  );

  modport master (
    output rdy_in, clear_flag, mem_din, io_buffer_full,
           full_mem, addr, data, op, if_req, if_addr,
    input  mem_dout, mem_a, mem_wr, mem_ready, mem_val, if_ready, if_data
  );
endinterface

// File: rtl/mem_ctrl.sv
// Memory controller between the load/store buffer and the byte-wide RAM/IO bus.
// Arbitrates LSB requests (priority) against instruction-fetch requests and
// serialises each access into 1/2/4 byte beats, returning a single registered
// ready pulse with the assembled (and for loads, extended) result.
// Ports:
//   clk_in    system clock
//   rst_n_in  asynchronous active-low reset
//   bus       mem_ctrl_if.slave: LSB, fetch and RAM/IO signals
module mem_ctrl #(
  parameter logic [31:0] IO_BASE     = 32'h30000,
  parameter int unsigned FETCH_BYTES = 4
) (
  input logic      clk_in,
  input logic      rst_n_in,
  mem_ctrl_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StLoad, StStore, StFetch, StDone} state_e;

  localparam logic [2:0] FetchN = 3'(FETCH_BYTES);

  state_e      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  op_q, op_d;
  logic [2:0]  nbytes_q, nbytes_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic [31:0] mem_val_q, mem_val_d;
  logic        mem_ready_q, mem_ready_d;
  logic [31:0] if_data_q, if_data_d;
  logic        if_ready_q, if_ready_d;

  logic        wr_en;
  logic        is_io;
  logic [31:0] assembled;
  logic [31:0] extended;
  logic [1:0]  cap_idx;
  logic [1:0]  nxt_idx;
  logic [2:0]  req_nbytes;

  assign is_io = (mem_a_q >= IO_BASE) && (mem_a_q <= IO_BASE + 32'd7);

  // Byte arriving on mem_din this cycle belongs to the beat issued last cycle.
  assign cap_idx = 2'(cnt_q - 3'd1);
  assign nxt_idx = 2'(cnt_q + 3'd1);

  always_comb begin
    assembled = buf_q;
    if (cnt_q != 3'd0) assembled[{cap_idx, 3'b000} +: 8] = bus.mem_din;
  end

  always_comb begin
    unique case (op_q[2:0])
      3'b000:  extended = {{24{assembled[7]}}, assembled[7:0]};
      3'b001:  extended = {{16{assembled[15]}}, assembled[15:0]};
      3'b100:  extended = {24'b0, assembled[7:0]};
      3'b101:  extended = {16'b0, assembled[15:0]};
      default: extended = assembled;
    endcase
  end

  always_comb begin
    unique case (bus.op[1:0])
      2'b00:   req_nbytes = 3'd1;
      2'b01:   req_nbytes = 3'd2;
      default: req_nbytes = 3'd4;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    data_d      = data_q;
    op_d        = op_q;
    nbytes_d    = nbytes_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_val_d   = mem_val_q;
    if_data_d   = if_data_q;
    // Ready outputs are single-cycle pulses even while rdy_in freezes the FSM.
    mem_ready_d = 1'b0;
    if_ready_d  = 1'b0;
    wr_en       = 1'b0;

    if (bus.rdy_in) begin
      unique case (state_q)
        StIdle: begin
          if (!bus.clear_flag) begin
            if (bus.full_mem) begin
              base_d   = bus.addr;
              data_d   = bus.data;
              op_d     = bus.op;
              nbytes_d = req_nbytes;
              cnt_d    = 3'd0;
              buf_d    = 32'b0;
              mem_a_d  = bus.addr;
              if (bus.op[3]) begin
                mem_dout_d = bus.data[7:0];
                state_d    = StStore;
              end else begin
                state_d = StLoad;
              end
            end else if (bus.if_req) begin
              base_d   = bus.if_addr;
              nbytes_d = FetchN;
              cnt_d    = 3'd0;
              buf_d    = 32'b0;
              mem_a_d  = bus.if_addr;
              state_d  = StFetch;
            end
          end
        end

        StLoad, StFetch: begin
          if (bus.clear_flag) begin
            state_d = StIdle;
          end else begin
            if (cnt_q != 3'd0) buf_d = assembled;
            if (cnt_q == nbytes_q) begin
              state_d = StDone;
              if (state_q == StLoad) begin
                mem_ready_d = 1'b1;
                mem_val_d   = extended;
              end else begin
                if_ready_d = 1'b1;
                if_data_d  = assembled;
              end
            end else begin
              cnt_d = cnt_q + 3'd1;
              if (cnt_q + 3'd1 < nbytes_q) mem_a_d = base_q + 32'(cnt_q + 3'd1);
            end
          end
        end

        // Stores are committed: clear_flag does not abort them.
        StStore: begin
          if (!(is_io && bus.io_buffer_full)) begin
            wr_en = 1'b1;
            if (cnt_q == nbytes_q - 3'd1) begin
              state_d     = StDone;
              mem_ready_d = 1'b1;
              mem_val_d   = 32'b0;
            end else begin
              cnt_d      = cnt_q + 3'd1;
              mem_a_d    = base_q + 32'(cnt_q + 3'd1);
              mem_dout_d = data_q[{nxt_idx, 3'b000} +: 8];
            end
          end
        end

        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= StIdle;
      base_q      <= 32'b0;
      data_q      <= 32'b0;
      op_q        <= 4'b0;
      nbytes_q    <= 3'd0;
      cnt_q       <= 3'd0;
      buf_q       <= 32'b0;
      mem_a_q     <= 32'b0;
      mem_dout_q  <= 8'b0;
      mem_val_q   <= 32'b0;
      mem_ready_q <= 1'b0;
      if_data_q   <= 32'b0;
      if_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      data_q      <= data_d;
      op_q        <= op_d;
      nbytes_q    <= nbytes_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_val_q   <= mem_val_d;
      mem_ready_q <= mem_ready_d;
      if_data_q   <= if_data_d;
      if_ready_q  <= if_ready_d;
    end
  end

  assign bus.mem_a     = mem_a_q;
  assign bus.mem_dout  = mem_dout_q;
  assign bus.mem_wr    = wr_en;
  assign bus.mem_val   = mem_val_q;
  assign bus.mem_ready = mem_ready_q;
  assign bus.if_data   = if_data_q;
  assign bus.if_ready  = if_ready_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus pushes expected writes / results,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_ctrl;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_ctrl_if bus ();

  mem_ctrl #(
    .IO_BASE    (32'h30000),
    .FETCH_BYTES(4)
  ) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus)
  );

  logic [7:0]  ram [0:4095];
  logic [31:0] exp_lsb[$];
  logic [31:0] exp_if[$];
  wr_t         exp_wr[$];

  int n_cmp = 0;
  int n_err = 0;
  int n_wr = 0;
  int n_rdy = 0;
  int n_ifr = 0;
  int cyc = 0;
  int t0 = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_wr) ram[bus.mem_a[11:0]] <= bus.mem_dout;
    bus.mem_din <= ram[bus.mem_a[11:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every DUT-presented write / ready pulse is checked against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_wr) begin
        n_wr++;
        if (exp_wr.size() == 0) begin
          chk("unexpected_write_addr", bus.mem_a, 32'hffff_ffff);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("write_addr", bus.mem_a, e.a);
          chk("write_data", {24'b0, bus.mem_dout}, {24'b0, e.d});
        end
      end
      if (bus.mem_ready) begin
        n_rdy++;
        if (exp_lsb.size() == 0) chk("unexpected_mem_ready", bus.mem_val, 32'hdead_dead);
        else chk("mem_val", bus.mem_val, exp_lsb.pop_front());
      end
      if (bus.if_ready) begin
        n_ifr++;
        if (exp_if.size() == 0) chk("unexpected_if_ready", bus.if_data, 32'hdead_dead);
        else chk("if_data", bus.if_data, exp_if.pop_front());
      end
    end
  end

  task automatic wait_lsb(output int lat);
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.mem_ready) begin
        lat = cyc - t0;
        return;
      end
    end
  endtask

  // Issues one LSB op (called at posedge+1 of an IDLE cycle), checks latency.
  task automatic run_lsb(input string name, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] o, input int exp_lat);
    int lat;
    bus.full_mem = 1'b1;
    bus.addr = a;
    bus.data = d;
    bus.op = o;
    @(posedge clk); #1;
    t0 = cyc;
    wait_lsb(lat);
    chk(name, lat, exp_lat);
    @(posedge clk); #1;
    bus.full_mem = 1'b0;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_wr.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_a"}, bus.mem_a, 32'h0);
    chk({tag, "_mem_dout"}, {24'b0, bus.mem_dout}, 32'h0);
    chk({tag, "_mem_val"}, bus.mem_val, 32'h0);
    chk({tag, "_if_data"}, bus.if_data, 32'h0);
    chk({tag, "_ctrl"}, {29'b0, bus.mem_wr, bus.mem_ready, bus.if_ready}, 32'h0);
  endtask

  initial begin
    int lat;
    int w0;
    int r0;
    int f0;
    int t_lsb;

    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h78; ram[12'h101] = 8'h56; ram[12'h102] = 8'h34; ram[12'h103] = 8'h12;
    ram[12'h104] = 8'h13; ram[12'h105] = 8'h00; ram[12'h106] = 8'h00; ram[12'h107] = 8'h93;
    ram[12'h200] = 8'h80; ram[12'h201] = 8'hf0;
    ram[12'h302] = 8'h5a;

    bus.rdy_in = 1'b1;
    bus.clear_flag = 1'b0;
    bus.io_buffer_full = 1'b0;
    bus.full_mem = 1'b0;
    bus.addr = 32'h0;
    bus.data = 32'h0;
    bus.op = 4'h0;
    bus.if_req = 1'b0;
    bus.if_addr = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Loads and extension.
    exp_lsb.push_back(32'h1234_5678); run_lsb("lw_lat", 32'h100, 32'h0, 4'b0010, 5);
    exp_lsb.push_back(32'hffff_ff80); run_lsb("lb_lat", 32'h200, 32'h0, 4'b0000, 2);
    exp_lsb.push_back(32'h0000_0080); run_lsb("lbu_lat", 32'h200, 32'h0, 4'b0100, 2);
    exp_lsb.push_back(32'hffff_f080); run_lsb("lh_lat", 32'h200, 32'h0, 4'b0001, 3);
    exp_lsb.push_back(32'h0000_f080); run_lsb("lhu_lat", 32'h200, 32'h0, 4'b0101, 3);
    exp_lsb.push_back(32'h0000_3456); run_lsb("lh_unaligned", 32'h101, 32'h0, 4'b0001, 3);

    // Halfword store: two beats, third byte untouched.
    w0 = n_wr;
    push_wr(32'h300, 8'hdd); push_wr(32'h301, 8'hcc); exp_lsb.push_back(32'h0);
    run_lsb("sh_lat", 32'h300, 32'haabb_ccdd, 4'b1001, 2);
    chk("sh_wr_cycles", n_wr - w0, 2);
    exp_lsb.push_back(32'h0000_005a); run_lsb("lbu_302", 32'h302, 32'h0, 4'b0100, 2);
    exp_lsb.push_back(32'h0000_ccdd); run_lsb("lhu_300", 32'h300, 32'h0, 4'b0101, 3);

    // IO store stalled by a full UART buffer for six cycles.
    w0 = n_wr;
    push_wr(32'h30000, 8'h41); exp_lsb.push_back(32'h0);
    bus.io_buffer_full = 1'b1;
    bus.full_mem = 1'b1; bus.addr = 32'h30000; bus.data = 32'h41; bus.op = 4'b1000;
    @(posedge clk); #1;
    t0 = cyc;
    repeat (6) @(negedge clk);
    chk("io_stall_no_wr", n_wr - w0, 0);
    @(posedge clk); #1;
    bus.io_buffer_full = 1'b0;
    wait_lsb(lat);
    chk("io_ready_lat", lat, 7);
    chk("io_one_write", n_wr - w0, 1);
    @(posedge clk); #1;
    bus.full_mem = 1'b0;

    // LSB and fetch raised together: LSB first, fetch after DONE.
    f0 = n_ifr;
    exp_lsb.push_back(32'h1234_5678); exp_if.push_back(32'h9300_0013);
    bus.full_mem = 1'b1; bus.addr = 32'h100; bus.op = 4'b0010;
    bus.if_req = 1'b1; bus.if_addr = 32'h104;
    @(posedge clk); #1;
    t0 = cyc;
    wait_lsb(t_lsb);
    chk("both_lsb_first_lat", t_lsb, 5);
    chk("both_no_fetch_yet", n_ifr - f0, 0);
    @(posedge clk); #1;
    bus.full_mem = 1'b0;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.if_ready) begin
        lat = cyc - t0;
        break;
      end
    end
    chk("both_fetch_lat", lat, 12);
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("both_fetch_once", n_ifr - f0, 1);

    // Flush during fetch beat 2: abort, no if_ready.
    f0 = n_ifr;
    bus.if_req = 1'b1; bus.if_addr = 32'h104;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.clear_flag = 1'b1;
    bus.if_req = 1'b0;
    @(negedge clk);
    chk("flush_fetch_beat2_addr", bus.mem_a, 32'h106);
    @(posedge clk); #1;
    bus.clear_flag = 1'b0;
    @(negedge clk);
    chk("flush_fetch_addr_held", bus.mem_a, 32'h106);
    repeat (8) @(posedge clk);
    #1;
    chk("flush_fetch_no_ready", n_ifr - f0, 0);

    // Flush during word store beat 1: all four bytes still written.
    w0 = n_wr;
    push_wr(32'h300, 8'h44); push_wr(32'h301, 8'h33);
    push_wr(32'h302, 8'h22); push_wr(32'h303, 8'h11);
    exp_lsb.push_back(32'h0);
    bus.full_mem = 1'b1; bus.addr = 32'h300; bus.data = 32'h1122_3344; bus.op = 4'b1010;
    @(posedge clk); #1;
    t0 = cyc;
    @(posedge clk); #1;
    bus.clear_flag = 1'b1;
    bus.full_mem = 1'b0;
    @(posedge clk); #1;
    bus.clear_flag = 1'b0;
    wait_lsb(lat);
    chk("flush_sw_ready_lat", lat, 4);
    chk("flush_sw_writes", n_wr - w0, 4);
    @(posedge clk); #1;
    exp_lsb.push_back(32'h1122_3344); run_lsb("lw_after_flush_sw", 32'h300, 32'h0, 4'b0010, 5);

    // rdy_in low freezes: no acceptance, no writes.
    w0 = n_wr;
    push_wr(32'h310, 8'h77); exp_lsb.push_back(32'h0);
    bus.rdy_in = 1'b0;
    bus.full_mem = 1'b1; bus.addr = 32'h310; bus.data = 32'h77; bus.op = 4'b1000;
    repeat (3) @(negedge clk);
    chk("freeze_no_wr", n_wr - w0, 0);
    @(posedge clk); #1;
    bus.rdy_in = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    wait_lsb(lat);
    chk("freeze_resume_lat", lat, 1);
    @(posedge clk); #1;
    bus.full_mem = 1'b0;

    // Asynchronous reset in the middle of a word store.
    r0 = n_rdy;
    push_wr(32'h300, 8'h88);
    bus.full_mem = 1'b1; bus.addr = 32'h300; bus.data = 32'hdead_be88; bus.op = 4'b1010;
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    chk("rst_pre_wr", {31'b0, bus.mem_wr}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    bus.full_mem = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_no_ready", n_rdy - r0, 0);

    chk("exp_wr_drained", exp_wr.size(), 0);
    chk("exp_lsb_drained", exp_lsb.size(), 0);
    chk("exp_if_drained", exp_if.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
